ex_div: RTL and testbench
=========================

# ex_div

Multi-cycle 32-bit integer divider living in the EX stage; it is the source of `stallreq_for_ex` consumed by the pipeline stall controller. While a DIV/DIVU occupies EX, it holds the request high until the quotient and remainder are ready, so the controller freezes EX and all earlier stages. Results go to the HI/LO write path in the same cycle the stall is released.

## Interface
Parameters: none (datapath fixed at 32 bits; iteration count fixed at 32).
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `div_start`  in  1  a DIV/DIVU is in EX; level, held stable while stalled
- `div_signed`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `div_start`
- `dividend`  in  32  rs operand; sampled in IDLE when `div_start`=1
- `divisor`  in  32  rt operand; sampled in IDLE when `div_start`=1
- `cancel`  in  1  flush of the EX instruction (exception/redirect); aborts any operation
- `stallreq_for_ex`  out  1  stall request to the stall controller
- `result_valid`  out  1  one-cycle pulse: `hi_o`/`lo_o` hold the result of the current EX instruction
- `lo_o`  out  32  quotient (registered)
- `hi_o`  out  32  remainder (registered)

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if `div_start`=1 and `cancel`=0, latch |dividend|, |divisor| (absolute values only when `div_signed`=1; raw values otherwise), quotient sign = dividend[31]^divisor[31], remainder sign = dividend[31] (both forced 0 when unsigned). Divisor = 0 → DONE; otherwise → BUSY with counter = 0.
- BUSY: one restoring step per cycle. 33-bit partial remainder R, 32-bit shift register Q (initially the dividend magnitude). Step: R' = {R[31:0], Q[31]}; if R' ≥ {1'b0, D}, then R = R' − D and shift 1 into Q, else R = R' and shift 0 into Q. Counter 5 bits; after the step with counter = 31 → DONE.
- On entry to DONE: `lo_o` = quotient (negated if quotient sign), `hi_o` = R[31:0] (negated if remainder sign). Divide by zero: `lo_o` = 32'hFFFF_FFFF, `hi_o` = dividend (raw).
- DONE → IDLE unconditionally. If `div_start` is still 1 in the following IDLE cycle, it is a new instruction (pipeline advanced) and starts a new operation.
- Overflow 0x8000_0000 / 0xFFFF_FFFF signed: `lo_o` = 0x8000_0000, `hi_o` = 0 (falls out of magnitude arithmetic; no special case).
- `stallreq_for_ex` = !`cancel` && ((IDLE && `div_start`) || BUSY). Combinational, so the request rises in the same cycle the instruction reaches EX.
- `result_valid` = DONE && !`cancel`.
- `cancel`=1 in any state: next state IDLE, no register update to `hi_o`/`lo_o`, outputs suppressed the same cycle.
- `rst`: state IDLE, counter 0, R/Q 0, `hi_o` = `lo_o` = 0. Both `stallreq_for_ex` and `result_valid` are 0 in every reset cycle regardless of inputs. Reset mid-BUSY discards the operation.

## Timing
- Nonzero divisor: the request is high for 33 cycles (1 IDLE + 32 BUSY). DONE is the 34th cycle, with the request low and `result_valid`=1; the pipeline advances at the end of DONE.
- Zero divisor: the request is high for 1 cycle, then DONE.
- `hi_o`/`lo_o` are valid from DONE onward and hold until the next DONE; they are never changed by cancel.
- Back-to-back divides: DONE→IDLE→start; there is no idle bubble beyond the IDLE start cycle.
- `div_*` operands are ignored outside IDLE; changes during BUSY have no effect.

## Test plan
- DIVU 100 / 7: request high for exactly 33 cycles, then DONE with `lo_o`=14, `hi_o`=2, `result_valid` high for 1 cycle.
- DIV −7 / 2 (0xFFFF_FFF9 / 2): `lo_o`=0xFFFF_FFFD, `hi_o`=0xFFFF_FFFF; DIV 7 / −2: `lo_o`=0xFFFF_FFFD, `hi_o`=1.
- DIV 0x8000_0000 / 0xFFFF_FFFF: `lo_o`=0x8000_0000, `hi_o`=0; DIVU 0xFFFF_FFFF / 1: `lo_o`=0xFFFF_FFFF, `hi_o`=0.
- Divisor 0 with dividend 0x1234: request high for 1 cycle, next cycle `result_valid`=1, `lo_o`=0xFFFF_FFFF, `hi_o`=0x1234.
- Cancel on BUSY cycle 10: request drops the same cycle, no `result_valid`, `hi_o`/`lo_o` keep prior values; the next start (DIVU 9 / 3) gives `lo_o`=3, `hi_o`=0 with full 33-cycle stall.
- `rst` asserted mid-BUSY for 1 cycle: outputs 0 next cycle, state IDLE; two back-to-back DIVUs (20/6, 21/4) give (3,2) then (5,1), with each DONE followed by a fresh 33-cycle stall.

Source files
------------

// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
// Module   : ex_div
// Purpose  : Multi-cycle 32-bit integer divider for the EX stage. Runs one
//            restoring-division step per cycle (32 steps) and raises
//            stallreq_for_ex while a DIV/DIVU is in flight so the stall
//            controller freezes EX and earlier stages. The quotient goes to
//            lo_o and the remainder to hi_o in the cycle the stall drops.
// Ports    : clk             - clock, rising edge
//            rst             - synchronous active-high reset
//            div_start       - DIV/DIVU present in EX (level)
//            div_signed      - 1 = DIV (two's complement), 0 = DIVU
//            dividend        - rs operand (sampled in IDLE)
//            divisor         - rt operand (sampled in IDLE)
//            cancel          - flush of the EX instruction, aborts operation
//            stallreq_for_ex - stall request to the pipeline controller
//            result_valid    - one-cycle pulse, hi_o/lo_o hold the result
//            lo_o            - quotient (registered)
//            hi_o            - remainder (registered)
// Revision : 1.0 - initial release
// ============================================================================
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        cancel,
  output logic        stallreq_for_ex,
  output logic        result_valid,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [4:0]  cnt;
  // The partial remainder is always below the divisor between steps, so its
  // top bit is permanently zero and only 32 bits need to be stored.
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvsr_r;
  logic        q_neg;
  logic        r_neg;

  // Operand conditioning in IDLE
  logic        dvd_neg;
  logic        dvs_neg;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic        divisor_zero;

  // One restoring step
  logic [32:0] r_shift;
  logic [32:0] r_diff;
  logic        step_ge;
  logic [31:0] r_next;
  logic [31:0] q_next;
  logic [31:0] lo_final;
  logic [31:0] hi_final;

  assign dvd_neg      = div_signed & dividend[31];
  assign dvs_neg      = div_signed & divisor[31];
  assign dvd_mag      = dvd_neg ? (~dividend + 32'd1) : dividend;
  assign dvs_mag      = dvs_neg ? (~divisor + 32'd1) : divisor;
  assign divisor_zero = (divisor == 32'd0);

  assign r_shift  = {rem_r, quo_r[31]};
  assign r_diff   = r_shift - {1'b0, dvsr_r};
  // No borrow out of the 33-bit subtract means R' >= D.
  assign step_ge  = ~r_diff[32];
  assign r_next   = step_ge ? r_diff[31:0] : r_shift[31:0];
  assign q_next   = {quo_r[30:0], step_ge};
  assign lo_final = q_neg ? (~q_next + 32'd1) : q_next;
  assign hi_final = r_neg ? (~r_next + 32'd1) : r_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt       = state;
    stallreq_for_ex = 1'b0;
    result_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (div_start && !cancel) begin
          state_nxt = divisor_zero ? DONE : BUSY;
        end
        stallreq_for_ex = div_start;
      end
      BUSY: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else if (cnt == 5'd31) begin
          state_nxt = DONE;
        end
        stallreq_for_ex = 1'b1;
      end
      DONE: begin
        state_nxt    = IDLE;
        result_valid = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // A flush or reset silences both handshakes in the same cycle.
    if (cancel || rst) begin
      stallreq_for_ex = 1'b0;
      result_valid    = 1'b0;
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 5'd0;
      rem_r  <= 32'd0;
      quo_r  <= 32'd0;
      dvsr_r <= 32'd0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      lo_o   <= 32'd0;
      hi_o   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start && !cancel) begin
            cnt    <= 5'd0;
            rem_r  <= 32'd0;
            quo_r  <= dvd_mag;
            dvsr_r <= dvs_mag;
            q_neg  <= dvd_neg ^ dvs_neg;
            r_neg  <= dvd_neg;
            if (divisor_zero) begin
              lo_o <= 32'hFFFF_FFFF;
              hi_o <= dividend;
            end
          end
        end
        BUSY: begin
          if (!cancel) begin
            rem_r <= r_next;
            quo_r <= q_next;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              lo_o <= lo_final;
              hi_o <= hi_final;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_div
// Purpose  : Self-checking bench for ex_div. Expected quotient/remainder
//            pairs are queued when a divide is launched and popped when the
//            DUT signals DONE.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        stallreq_for_ex;
  logic        result_valid;
  logic [31:0] lo_o;
  logic [31:0] hi_o;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  ex_div dut (
    .clk             (clk),
    .rst             (rst),
    .div_start       (div_start),
    .div_signed      (div_signed),
    .dividend        (dividend),
    .divisor         (divisor),
    .cancel          (cancel),
    .stallreq_for_ex (stallreq_for_ex),
    .result_valid    (result_valid),
    .lo_o            (lo_o),
    .hi_o            (hi_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: 64-bit arithmetic avoids the signed overflow corner.
  task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
  endtask

  // Launch a divide at the next negedge, count stall cycles, then check DONE.
  // div_start is left high; the caller decides whether the next instruction
  // follows back-to-back.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e_lo,
                         input logic [31:0] e_hi, input int e_cycles);
    int   cycles;
    exp_t e;
    exp_t got_e;
    e.lo = e_lo;
    e.hi = e_hi;
    exp_q.push_back(e);
    @(negedge clk);
    div_start  = 1'b1;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    cycles     = 0;
    #1;
    while (stallreq_for_ex && cycles < 40) begin
      if (result_valid) check({tag, "_valid_during_stall"}, 32'(result_valid), 32'd0);
      cycles++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stall_cycles"}, 32'(cycles), 32'(e_cycles));
    check({tag, "_result_valid"}, 32'(result_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      got_e = exp_q.pop_front();
      check({tag, "_lo"}, lo_o, got_e.lo);
      check({tag, "_hi"}, hi_o, got_e.hi);
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    div_start = 1'b0;
    cancel    = 1'b0;
    #1;
    check({tag, "_idle_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_idle_stall"}, 32'(stallreq_for_ex), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mq;
    logic [31:0] mr;
    logic        rs;
    int          ec;

    rst        = 1'b1;
    div_start  = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd5;
    divisor    = 32'd1;
    cancel     = 1'b0;

    // Reset state: handshakes low even with div_start asserted.
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(stallreq_for_ex), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_lo", lo_o, 32'd0);
    check("rst_hi", hi_o, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    div_start = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    idle_cycle("after_100_7");
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    idle_cycle("after_m7_2");
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    idle_cycle("after_7_m2");
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    idle_cycle("after_ovf");
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
    idle_cycle("after_max_1");
    run_div("div_zero", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1);
    idle_cycle("after_zero");

    // Cancel on BUSY cycle 10: result of the zero-divide must persist.
    @(negedge clk);
    div_start  = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd1000;
    divisor    = 32'd10;
    repeat (11) @(negedge clk);  // IDLE start cycle + BUSY cycles 0..9
    cancel = 1'b1;
    #1;
    check("cancel_stall", 32'(stallreq_for_ex), 32'd0);
    check("cancel_valid", 32'(result_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle_cycle("post_cancel");
      check("cancel_keep_lo", lo_o, 32'hFFFF_FFFF);
      check("cancel_keep_hi", hi_o, 32'h0000_1234);
    end
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
    idle_cycle("after_9_3");

    // Reset mid-BUSY.
    @(negedge clk);
    div_start = 1'b1;
    dividend  = 32'd50;
    divisor   = 32'd3;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_stall", 32'(stallreq_for_ex), 32'd0);
    check("midrst_valid", 32'(result_valid), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    div_start = 1'b0;
    #1;
    check("midrst_lo", lo_o, 32'd0);
    check("midrst_hi", hi_o, 32'd0);
    check("midrst_stall_after", 32'(stallreq_for_ex), 32'd0);
    check("midrst_valid_after", 32'(result_valid), 32'd0);

    // Back-to-back DIVUs with no extra bubble.
    run_div("b2b_20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 33);
    run_div("b2b_21_4", 1'b0, 32'd21, 32'd4, 32'd5, 32'd1, 33);
    idle_cycle("after_b2b");

    // Randomised operands against the reference model.
    for (int k = 0; k < 10; k++) begin
      ra = $urandom;
      rb = (k == 3) ? 32'd0 : ((k % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      rs = k[0];
      model(rs, ra, rb, mq, mr);
      ec = (rb == 32'd0) ? 1 : 33;
      run_div("rand", rs, ra, rb, mq, mr, ec);
      idle_cycle("after_rand");
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
